// File: rtl/branch_predictor.sv
// branch_predictor: BTB-based next-PC predictor for the pipelined TSC core.
// It supplies a predicted next PC to IF every cycle. It also checks the
// prediction carried down to ID against the resolved outcome, and it drives
// jump_miss/branch_miss to the hazard unit.
// Define BRANCH_PREDICT_EN to build the BTB. When the macro is undefined, no
// table is built. Every control transfer then reports a miss, which makes the
// pipeline stall on each jump or branch.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc_if,
    output logic [15:0] pred_next_pc,
    output logic        pred_taken,
    input  logic        resolve_valid,
    input  logic        id_stall,
    input  logic [15:0] pc_id,
    input  logic [15:0] pred_next_pc_id,
    input  logic        resolve_is_jump,
    input  logic        resolve_is_branch,
    input  logic        resolve_taken,
    input  logic [15:0] resolve_target,
    output logic        jump_miss,
    output logic        branch_miss,
    output logic [15:0] correct_pc,
    output logic [15:0] num_miss
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 16 - IDX_BITS;

    logic [15:0] pc_if_inc;
    logic [15:0] pc_id_inc;
    logic [15:0] actual;
    logic        xfer_taken;
    logic        commit;
    logic        mispredict;

    // Jumps are always taken, so only branches consult resolve_taken.
    assign pc_if_inc  = pc_if + 16'd1;
    assign pc_id_inc  = pc_id + 16'd1;
    assign xfer_taken = resolve_is_jump || resolve_taken;
    assign actual     = xfer_taken ? resolve_target : pc_id_inc;
    assign correct_pc = actual;

    // A stalled ID instruction is held until its last, unstalled cycle.
    // Only that cycle commits, so each instruction updates the table once.
    assign commit     = resolve_valid && !id_stall && (resolve_is_jump || resolve_is_branch);
    assign mispredict = jump_miss || branch_miss;

    // Count the misses that are committed; the counter wraps at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_miss <= '0;
        end else if (commit && mispredict) begin
            num_miss <= num_miss + 16'd1;
        end
    end

`ifdef BRANCH_PREDICT_EN
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  is_jump_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [15:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] idx_if;
    logic [IDX_BITS-1:0] idx_id;
    logic [TAG_W-1:0]    tag_if;
    logic [TAG_W-1:0]    tag_id;
    logic                hit_if;
    logic                hit_id;
    logic                pred_wrong;

    // IF reads the registered table. A write to the same index in this cycle
    // is not bypassed, so IF sees the old entry until the next cycle.
    assign idx_if       = pc_if[IDX_BITS-1:0];
    assign tag_if       = pc_if[15:IDX_BITS];
    assign hit_if       = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign pred_taken   = hit_if && (is_jump_q[idx_if] || ctr_q[idx_if][1]);
    assign pred_next_pc = pred_taken ? target_q[idx_if] : pc_if_inc;

    assign idx_id       = pc_id[IDX_BITS-1:0];
    assign tag_id       = pc_id[15:IDX_BITS];
    assign hit_id       = valid_q[idx_id] && (tag_q[idx_id] == tag_id);
    assign pred_wrong   = pred_next_pc_id != actual;
    assign jump_miss    = resolve_valid && resolve_is_jump && pred_wrong;
    assign branch_miss  = resolve_valid && resolve_is_branch && pred_wrong;

    // Table update. A hit trains the counter and retargets the entry when
    // the transfer is taken. A taken miss allocates the entry and evicts any
    // alias. A not-taken miss leaves the table unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            is_jump_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (commit) begin
            if (hit_id) begin
                if (xfer_taken) begin
                    target_q[idx_id] <= resolve_target;
                    if (ctr_q[idx_id] != 2'b11) begin
                        ctr_q[idx_id] <= ctr_q[idx_id] + 2'd1;
                    end
                end else if (ctr_q[idx_id] != 2'b00) begin
                    ctr_q[idx_id] <= ctr_q[idx_id] - 2'd1;
                end
            end else if (xfer_taken) begin
                valid_q[idx_id]   <= 1'b1;
                tag_q[idx_id]     <= tag_id;
                target_q[idx_id]  <= resolve_target;
                is_jump_q[idx_id] <= resolve_is_jump;
                ctr_q[idx_id]     <= 2'b10;
            end
        end
    end
`else
    logic unused_pred_id;

    // With no table, fall through to PC+1 and redirect on every control
    // transfer. The carried prediction then has no use.
    assign pred_taken     = 1'b0;
    assign pred_next_pc   = pc_if_inc;
    assign jump_miss      = resolve_valid && resolve_is_jump;
    assign branch_miss    = resolve_valid && resolve_is_branch;
    assign unused_pred_id = ^pred_next_pc_id;
`endif

endmodule
